// File: rtl/sensor_pkg.sv
// Shared types and defaults for the alarm front-end sensor conditioner.
package sensor_pkg;

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    MED  = 2'd1,
    HIGH = 2'd2
  } smoke_state_t;

  localparam int DEF_SMOKE_W       = 8;
  localparam int DEF_TH_MED        = 80;
  localparam int DEF_TH_HIGH       = 160;
  localparam int DEF_HYST          = 8;
  localparam int DEF_SMOKE_CONFIRM = 3;
  localparam int DEF_DEB_CYCLES    = 16;

  // Hold bands must stay positive and must not overlap the next class down.
  function automatic bit params_legal(input int smoke_w, input int th_med,
                                      input int th_high, input int hyst,
                                      input int confirm, input int deb);
    return (th_med > hyst) && (th_high - hyst > th_med) &&
           (th_high < (1 << smoke_w)) && (confirm >= 1) && (deb >= 2);
  endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Sample/level bundle between the sensor inputs and the conditioned flags.
interface sensor_conditioner_if
  import sensor_pkg::*;
#(
  parameter int SMOKE_W = DEF_SMOKE_W
);
  logic [SMOKE_W-1:0] smoke_level;
  logic               smoke_valid;
  logic               glp_raw;
  logic               fe_raw;
  logic               apag_raw;
  logic               humom;
  logic               humoa;
  logic               glp;
  logic               fe;
  logic               apagsis;
  logic               change;

  modport master (
    output smoke_level, smoke_valid, glp_raw, fe_raw, apag_raw,
    input  humom, humoa, glp, fe, apagsis, change
  );

  modport slave (
    input  smoke_level, smoke_valid, glp_raw, fe_raw, apag_raw,
    output humom, humoa, glp, fe, apagsis, change
  );
endinterface

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus stability counter for one async digital line.
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic flip
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // flip tells the parent that level toggles on the coming edge.
  assign flip = (sync2 != level) && (cnt == CW'(DEB_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Smoke classifier with hysteresis/confirmation plus three debounced digital
// lines; change pulses in the cycle any conditioned flag takes a new value.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int SMOKE_W       = DEF_SMOKE_W,
  parameter int TH_MED        = DEF_TH_MED,
  parameter int TH_HIGH       = DEF_TH_HIGH,
  parameter int HYST          = DEF_HYST,
  parameter int SMOKE_CONFIRM = DEF_SMOKE_CONFIRM,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES
) (
  input logic                 clk,
  input logic                 reset,
  sensor_conditioner_if.slave bus
);
  localparam int CW = $clog2(SMOKE_CONFIRM + 1);

  localparam logic [SMOKE_W-1:0] HIGH_ENTER = SMOKE_W'(TH_HIGH);
  localparam logic [SMOKE_W-1:0] HIGH_HOLD  = SMOKE_W'(TH_HIGH - HYST);
  localparam logic [SMOKE_W-1:0] MED_ENTER  = SMOKE_W'(TH_MED);
  localparam logic [SMOKE_W-1:0] MED_HOLD   = SMOKE_W'(TH_MED - HYST);

  if (!params_legal(SMOKE_W, TH_MED, TH_HIGH, HYST, SMOKE_CONFIRM, DEB_CYCLES))
  begin : g_bad_params
    $error("sensor_conditioner: illegal threshold/hysteresis parameters");
  end

  smoke_state_t  state;
  smoke_state_t  state_next;
  smoke_state_t  cand;
  smoke_state_t  cand_next;
  smoke_state_t  smoke_class;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] run_len;
  logic          glp_flip;
  logic          fe_flip;
  logic          apag_flip;

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_glp (
    .clk(clk), .reset(reset), .raw(bus.glp_raw), .level(bus.glp), .flip(glp_flip)
  );

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_fe (
    .clk(clk), .reset(reset), .raw(bus.fe_raw), .level(bus.fe), .flip(fe_flip)
  );

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_apag (
    .clk(clk), .reset(reset), .raw(bus.apag_raw), .level(bus.apagsis), .flip(apag_flip)
  );

  // Hold bands only apply when already in (or above) the class being held.
  always_comb begin
    smoke_class = LOW;
    if (bus.smoke_level >= HIGH_ENTER)
      smoke_class = HIGH;
    else if (state == HIGH && bus.smoke_level >= HIGH_HOLD)
      smoke_class = HIGH;
    else if (bus.smoke_level >= MED_ENTER)
      smoke_class = MED;
    else if (state != LOW && bus.smoke_level >= MED_HOLD)
      smoke_class = MED;
  end

  always_comb begin
    state_next = state;
    cand_next  = cand;
    cnt_next   = cnt;
    run_len    = '0;
    if (bus.smoke_valid) begin
      if (smoke_class == state) begin
        cnt_next = '0;
      end else begin
        run_len   = (smoke_class == cand) ? cnt + CW'(1) : CW'(1);
        cand_next = smoke_class;
        if (run_len == CW'(SMOKE_CONFIRM)) begin
          state_next = smoke_class;
          cnt_next   = '0;
        end else begin
          cnt_next = run_len;
        end
      end
    end
  end

  // Flags are loaded from next-state so change lines up with the new values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOW;
      cand       <= LOW;
      cnt        <= '0;
      bus.humom  <= 1'b0;
      bus.humoa  <= 1'b0;
      bus.change <= 1'b0;
    end else begin
      state      <= state_next;
      cand       <= cand_next;
      cnt        <= cnt_next;
      bus.humom  <= (state_next == MED);
      bus.humoa  <= (state_next == HIGH);
      bus.change <= (state_next != state) | glp_flip | fe_flip | apag_flip;
    end
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner: debounce latency/glitch rejection,
// smoke classification table and reset re-qualification.
module tb_sensor_conditioner;

  typedef struct {
    logic       valid;
    logic [7:0] level;
    logic [5:0] exp;
  } smoke_vec_t;

  logic clk = 1'b0;
  logic reset;
  int   check_count = 0;
  int   pass_count  = 0;

  smoke_vec_t vecs[$];

  sensor_conditioner_if #(.SMOKE_W(8)) bus ();

  sensor_conditioner dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] level);
    bus.smoke_valid = valid;
    bus.smoke_level = level;
    tick();
    bus.smoke_valid = 1'b0;
  endtask

  // Expected word order: {humom, humoa, glp, fe, apagsis, change}
  task automatic checkOutput(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {bus.humom, bus.humoa, bus.glp, bus.fe, bus.apagsis, bus.change};
    check_count++;
    if (act === exp)
      pass_count++;
    else
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
  endtask

  initial begin
    reset           = 1'b1;
    bus.smoke_valid = 1'b0;
    bus.smoke_level = 8'd0;
    bus.glp_raw     = 1'b0;
    bus.fe_raw      = 1'b0;
    bus.apag_raw    = 1'b0;
    repeat (2) tick();
    checkOutput("reset_state", 6'b000000);
    reset = 1'b0;

    for (int i = 0; i < 50; i++) begin
      tick();
      checkOutput($sformatf("idle_%0d", i), 6'b000000);
    end

    $display("[TB] glp debounce latency");
    bus.glp_raw = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      checkOutput($sformatf("glp_rise_wait_%0d", i), 6'b000000);
    end
    tick();
    checkOutput("glp_rise_edge18", 6'b001001);
    tick();
    checkOutput("glp_rise_hold", 6'b001000);
    bus.glp_raw = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      checkOutput($sformatf("glp_fall_wait_%0d", i), 6'b001000);
    end
    tick();
    checkOutput("glp_fall_edge18", 6'b000001);
    tick();
    checkOutput("glp_fall_hold", 6'b000000);

    $display("[TB] fe glitch rejection");
    bus.fe_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("fe_glitch_hi_%0d", i), 6'b000000);
    end
    bus.fe_raw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput($sformatf("fe_glitch_lo_%0d", i), 6'b000000);
    end

    $display("[TB] smoke classification table");
    vecs.push_back('{1'b1, 8'd90,  6'b000000});
    vecs.push_back('{1'b1, 8'd90,  6'b000000});
    vecs.push_back('{1'b1, 8'd90,  6'b100001});
    vecs.push_back('{1'b1, 8'd75,  6'b100000});
    vecs.push_back('{1'b1, 8'd75,  6'b100000});
    vecs.push_back('{1'b1, 8'd75,  6'b100000});
    vecs.push_back('{1'b1, 8'd71,  6'b100000});
    vecs.push_back('{1'b1, 8'd71,  6'b100000});
    vecs.push_back('{1'b1, 8'd71,  6'b000001});
    vecs.push_back('{1'b1, 8'd79,  6'b000000});
    vecs.push_back('{1'b1, 8'd79,  6'b000000});
    vecs.push_back('{1'b1, 8'd79,  6'b000000});
    vecs.push_back('{1'b1, 8'd80,  6'b000000});
    vecs.push_back('{1'b1, 8'd80,  6'b000000});
    vecs.push_back('{1'b1, 8'd80,  6'b100001});
    vecs.push_back('{1'b1, 8'd72,  6'b100000});
    vecs.push_back('{1'b1, 8'd72,  6'b100000});
    vecs.push_back('{1'b1, 8'd72,  6'b100000});
    vecs.push_back('{1'b1, 8'd10,  6'b100000});
    vecs.push_back('{1'b1, 8'd10,  6'b100000});
    vecs.push_back('{1'b1, 8'd10,  6'b000001});
    vecs.push_back('{1'b1, 8'd200, 6'b000000});
    vecs.push_back('{1'b1, 8'd100, 6'b000000});
    vecs.push_back('{1'b1, 8'd200, 6'b000000});
    vecs.push_back('{1'b1, 8'd200, 6'b000000});
    vecs.push_back('{1'b1, 8'd200, 6'b010001});
    vecs.push_back('{1'b1, 8'd152, 6'b010000});
    vecs.push_back('{1'b1, 8'd152, 6'b010000});
    vecs.push_back('{1'b1, 8'd152, 6'b010000});
    vecs.push_back('{1'b1, 8'd151, 6'b010000});
    vecs.push_back('{1'b1, 8'd151, 6'b010000});
    vecs.push_back('{1'b1, 8'd151, 6'b100001});
    vecs.push_back('{1'b1, 8'd160, 6'b100000});
    vecs.push_back('{1'b1, 8'd160, 6'b100000});
    vecs.push_back('{1'b1, 8'd160, 6'b010001});
    vecs.push_back('{1'b1, 8'd50,  6'b010000});
    vecs.push_back('{1'b0, 8'd0,   6'b010000});
    vecs.push_back('{1'b1, 8'd50,  6'b010000});
    vecs.push_back('{1'b1, 8'd50,  6'b000001});
    vecs.push_back('{1'b1, 8'd255, 6'b000000});
    vecs.push_back('{1'b1, 8'd255, 6'b000000});
    vecs.push_back('{1'b1, 8'd255, 6'b010001});
    vecs.push_back('{1'b0, 8'd0,   6'b010000});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].level);
      checkOutput($sformatf("smoke_vec_%0d_lvl_%0d", i, vecs[i].level), vecs[i].exp);
    end

    $display("[TB] reset while HIGH with apag pending");
    bus.apag_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checkOutput($sformatf("apag_pre_reset_%0d", i), 6'b010000);
    end
    reset = 1'b1;
    #1;
    checkOutput("reset_async_clear", 6'b000000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      checkOutput($sformatf("apag_requal_wait_%0d", i), 6'b000000);
    end
    tick();
    checkOutput("apag_requal_edge18", 6'b000011);
    tick();
    checkOutput("apag_requal_hold", 6'b000010);

    applyStimulus(1'b1, 8'd200);
    checkOutput("smoke_requal_1", 6'b000010);
    applyStimulus(1'b1, 8'd160);
    checkOutput("smoke_requal_2", 6'b000010);
    applyStimulus(1'b1, 8'd200);
    checkOutput("smoke_requal_3", 6'b010011);
    tick();
    checkOutput("smoke_requal_settle", 6'b010010);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
